hex2dec_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the four-digit multiplexed seven-segment driver. It accepts a 14-bit count (packet, match or drop count) over a valid/ready handshake and runs a 14-cycle shift-and-add-3 conversion. It then updates four 5-bit digit codes atomically, so the display never shows a partially converted value. Values above 9999 show as four dashes.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 16 +
 rtl/hex2dec_seq.sv | 137 +++++++++++++
 tb/tb_hex2dec_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment display path
//
// Purpose: digit code constants, converter FSM state type and the default
// largest displayable value, shared by the converter and the display driver.
// Ports: none (package).
package seg7_pkg;

  // Digit code: bit 4 selects the dash glyph, bits 3:0 carry a BCD digit.
  localparam logic [4:0] DIG_DASH = 5'h10;
  localparam logic [4:0] DIG_ZERO = 5'h00;

  // Four display digits, so the BCD accumulator is four nibbles wide.
  localparam int BCD_DIGITS = 4;

  // Largest value the four-digit display can show.
  localparam int MAX_VAL_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction (+3 when nibble >= 5)
//
// Purpose: conditional add-3 applied to one BCD nibble before each shift so
// that the following doubling carries correctly into the next decimal digit.
// Ports:
//   nib_i  in  4 : BCD nibble before correction
//   nib_o  out 4 : nib_i + 3 if nib_i >= 5, otherwise nib_i
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Valid BCD inputs are 0..9, so the sum never exceeds 12 and fits 4 bits.
  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/hex2dec_seq.sv
// rtl/hex2dec_seq.sv - sequential binary-to-BCD converter for the 4-digit display
//
// Purpose: accepts an unsigned WIDTH-bit count over a valid/ready handshake,
// converts it with WIDTH cycles of shift-and-add-3, then updates all four
// digit codes at once. Values above MAX_VAL display as four dashes.
// Ports:
//   clk       in  1     : clock, rising edge
//   rst_n     in  1     : synchronous active-low reset
//   in_valid  in  1     : in_value is presented for conversion
//   in_value  in  WIDTH : unsigned binary value
//   in_ready  out 1     : converter idle and able to accept a value
//   digit0..3 out 5     : digit codes ones..thousands (bit 4 dash, 3:0 BCD)
//   done      out 1     : one-cycle pulse, digits were just updated
//   ovf       out 1     : displayed value is an overflow
module hex2dec_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic [4:0]       digit0,
  output logic [4:0]       digit1,
  output logic [4:0]       digit2,
  output logic [4:0]       digit3,
  output logic             done,
  output logic             ovf
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int              BCD_W    = 4 * BCD_DIGITS;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);

  state_t                         state_q, state_d;
  logic [WIDTH-1:0]               sr_q, sr_d;
  logic [BCD_W-1:0]               bcd_q, bcd_d;
  logic [BCD_W-1:0]               bcd_adj;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           ovf_pend_q, ovf_pend_d;
  logic [BCD_DIGITS-1:0][4:0]     dig_q, dig_d;
  logic                           ovf_q, ovf_d;
  logic                           done_q, done_d;
  logic                           in_over;

  // Per-nibble correction on the pre-shift accumulator.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign in_over = (32'(in_value) > $unsigned(MAX_VAL));

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d       = in_value;
          bcd_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = in_over;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // Corrected BCD and the remaining binary bits shift as one register;
        // the binary MSB enters the ones nibble. Thousands carry-out is lost,
        // which only happens for overflow values that display dashes anyway.
        {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
          dig_d[i] = ovf_pend_q ? DIG_DASH : {1'b0, bcd_q[4*i +: 4]};
        end
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      dig_q      <= {BCD_DIGITS{DIG_ZERO}};
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign digit0   = dig_q[0];
  assign digit1   = dig_q[1];
  assign digit2   = dig_q[2];
  assign digit3   = dig_q[3];
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_hex2dec_seq.sv
// tb/tb_hex2dec_seq.sv - scoreboard testbench for hex2dec_seq
module tb_hex2dec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] in_value;
  logic        in_ready;
  logic [4:0]  digit0, digit1, digit2, digit3;
  logic        done;
  logic        ovf;

  always #5 clk = ~clk;

  hex2dec_seq #(.WIDTH(14), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .done     (done),
    .ovf      (ovf)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [20:0] exp_q[$];
  logic [20:0] exp_e;
  logic [20:0] cur_state;
  logic [20:0] prev_state = '0;
  logic        prev_rstn  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected entry layout: {digit3, digit2, digit1, digit0, ovf}.
  function automatic logic [20:0] exp4(input logic [4:0] d3, input logic [4:0] d2,
                                       input logic [4:0] d1, input logic [4:0] d0,
                                       input logic o);
    return {d3, d2, d1, d0, o};
  endfunction

  function automatic logic [20:0] model(input int v);
    if (v > 9999) return {5'h10, 5'h10, 5'h10, 5'h10, 1'b1};
    return {1'b0, 4'((v / 1000) % 10), 1'b0, 4'((v / 100) % 10),
            1'b0, 4'((v / 10) % 10), 1'b0, 4'(v % 10), 1'b0};
  endfunction

  // Monitor: pops the scoreboard on every done pulse; between pulses the
  // displayed value must hold unless reset was applied.
  always @(negedge clk) begin
    cur_state = {digit3, digit2, digit1, digit0, ovf};
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0h required=none", cur_state);
      end else begin
        exp_e = exp_q.pop_front();
        check("digits_at_done", 32'(cur_state[20:1]), 32'(exp_e[20:1]));
        check("ovf_at_done", 32'(cur_state[0]), 32'(exp_e[0]));
      end
    end else if (prev_rstn && rst_n) begin
      check("display_hold", 32'(cur_state), 32'(prev_state));
    end
    prev_state = cur_state;
    prev_rstn  = rst_n;
  end

  // Called just after a rising edge; returns once in_ready is high.
  task automatic wait_ready();
    for (int i = 0; i < 64; i++) begin
      if (in_ready) return;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL ready_timeout actual=0 required=1");
  endtask

  task automatic send(input int v);
    wait_ready();
    in_valid = 1'b1;
    in_value = 14'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Ends on the falling edge where done is high (or after the bound).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=0 required=1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, low_cnt, t1, t2, dc0, ta, tprev;
    logic rdy_at_done;
    int bvals[4];

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("reset_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // 1234: latency and busy window.
    exp_q.push_back(exp4(5'h01, 5'h02, 5'h03, 5'h04, 1'b0));
    send(1234);
    n = 0;
    low_cnt = 0;
    rdy_at_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (!in_ready) low_cnt++;
      if (done) begin
        rdy_at_done = in_ready;
        break;
      end
    end
    check("latency_1234", 32'(n), 32'd16);
    check("ready_low_cycles", 32'(low_cnt), 32'd15);
    check("ready_at_done", 32'(rdy_at_done), 32'h1);
    @(posedge clk);
    #1;

    // Boundaries.
    bvals = '{0, 9999, 10000, 16383};
    exp_q.push_back(exp4(5'h00, 5'h00, 5'h00, 5'h00, 1'b0));
    exp_q.push_back(exp4(5'h09, 5'h09, 5'h09, 5'h09, 1'b0));
    exp_q.push_back(exp4(5'h10, 5'h10, 5'h10, 5'h10, 1'b1));
    exp_q.push_back(exp4(5'h10, 5'h10, 5'h10, 5'h10, 1'b1));
    foreach (bvals[k]) begin
      send(bvals[k]);
      wait_done(n);
      @(posedge clk);
      #1;
    end

    // 42 presented while 7 converts.
    exp_q.push_back(exp4(5'h00, 5'h00, 5'h00, 5'h07, 1'b0));
    exp_q.push_back(exp4(5'h00, 5'h00, 5'h04, 5'h02, 1'b0));
    send(7);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_value = 14'd42;
    @(negedge clk);
    check("busy_not_ready", 32'(in_ready), 32'h0);
    wait_done(n);
    t1 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(n);
    t2 = cyc;
    check("second_done_spacing", 32'(t2 - t1), 32'd16);
    @(posedge clk);
    #1;

    // Reset in the middle of converting 8888.
    dc0 = done_cnt;
    send(8888);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'h1);
    check("digits_after_reset", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    check("ovf_after_reset", 32'(ovf), 32'h0);
    repeat (25) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(dc0));
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    tprev = 0;
    for (int v = 0; v <= 20; v++) begin
      in_value = 14'(v);
      exp_q.push_back(model(v));
      wait_ready();
      @(posedge clk);
      #1;
      ta = cyc;
      if (v > 0) check("accept_spacing", 32'(ta - tprev), 32'd16);
      tprev = ta;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
